// File: rtl/misc_fifo_pkg.sv
// Shared definitions for the misc-library FIFOs: read-mode selectors and
// the default almost-full threshold.
package misc_fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   // Default almost-full threshold is one word short of the full depth.
   function automatic int default_af_level(input int pwidth);
      return (32'sd1 <<< pwidth) - 32'sd1;
   endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Register-file storage for param_fifo: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fifo_dpram #(
   parameter int FBITS  = 8,
   parameter int PWIDTH = 3
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PWIDTH-1:0] waddr,
   input  logic [FBITS-1:0]  wdata,
   input  logic [PWIDTH-1:0] raddr,
   output logic [FBITS-1:0]  rdata
);

   logic [FBITS-1:0] mem_r [0:(2**PWIDTH)-1];

   // Write port: store the word on an enabled rising edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through
// read mode, programmable almost flags and sticky overflow/underflow.
module param_fifo
   import misc_fifo_pkg::*;
#(
   parameter int FBITS    = 8,
   parameter int PWIDTH   = 3,
   parameter int FDEPTH   = 32'sd1 <<< PWIDTH,
   parameter int AF_LEVEL = default_af_level(PWIDTH),
   parameter int AE_LEVEL = 1,
   parameter int FWFT     = FIFO_STD
) (
   input  logic              clk,
   input  logic              clr_fifo,
   input  logic              wr_fifo,
   input  logic [FBITS-1:0]  data_in,
   input  logic              rd_fifo,
   output logic [FBITS-1:0]  data_out,
   output logic              data_out_valid,
   output logic [PWIDTH:0]   data_counter,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);

   if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= FDEPTH) && (PWIDTH >= 1) &&
         (FDEPTH == (32'sd1 <<< PWIDTH)))) begin : g_bad_params
      $error("param_fifo: illegal parameter combination");
   end

   localparam logic [PWIDTH-1:0] PTR_ONE_C = PWIDTH'(32'd1);
   localparam logic [PWIDTH:0]   CNT_ONE_C = (PWIDTH+1)'(32'd1);
   localparam logic [PWIDTH:0]   CNT_ZERO_C = (PWIDTH+1)'(32'd0);
   localparam logic [PWIDTH:0]   FULL_LVL_C = (PWIDTH+1)'(FDEPTH);
   localparam logic [PWIDTH:0]   AF_LVL_C   = (PWIDTH+1)'(AF_LEVEL);
   localparam logic [PWIDTH:0]   AE_LVL_C   = (PWIDTH+1)'(AE_LEVEL);

   logic [PWIDTH-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_next_s, rd_addr_s;
   logic [PWIDTH:0]   count_r, count_next_s, count_after_rd_s;
   logic [FBITS-1:0]  dout_r, dout_next_s, mem_rdata_s;
   logic              valid_r, valid_next_s, ovf_r, udf_r;
   logic              wr_acc_s, rd_acc_s, empty_s, full_s;

   fifo_dpram #(
      .FBITS  (FBITS),
      .PWIDTH (PWIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc_s & ~clr_fifo),
      .waddr (wr_ptr_r),
      .wdata (data_in),
      .raddr (rd_addr_s),
      .rdata (mem_rdata_s)
   );

   assign empty_s = (count_r == CNT_ZERO_C);
   assign full_s  = (count_r == FULL_LVL_C);

   // Accept decisions, next pointer/count and next output word.
   always_comb begin
      wr_acc_s         = wr_fifo & ~full_s;
      rd_acc_s         = rd_fifo & ~empty_s;
      rd_ptr_next_s    = rd_acc_s ? (rd_ptr_r + PTR_ONE_C) : rd_ptr_r;
      count_after_rd_s = rd_acc_s ? (count_r - CNT_ONE_C) : count_r;
      case ({wr_acc_s, rd_acc_s})
         2'b10:   count_next_s = count_r + CNT_ONE_C;
         2'b01:   count_next_s = count_r - CNT_ONE_C;
         default: count_next_s = count_r;
      endcase
      rd_addr_s    = rd_ptr_r;
      dout_next_s  = dout_r;
      valid_next_s = 1'b0;
      if (FWFT == FIFO_FWFT) begin
         // Present the oldest word after this edge; an otherwise-empty
         // FIFO takes the incoming word straight from data_in.
         rd_addr_s    = rd_ptr_next_s;
         valid_next_s = (count_next_s != CNT_ZERO_C);
         if (wr_acc_s && (count_after_rd_s == CNT_ZERO_C)) begin
            dout_next_s = data_in;
         end else if (count_next_s != CNT_ZERO_C) begin
            dout_next_s = mem_rdata_s;
         end else begin
            dout_next_s = dout_r;
         end
      end else begin
         if (rd_acc_s) begin
            dout_next_s  = mem_rdata_s;
            valid_next_s = 1'b1;
         end else begin
            dout_next_s  = dout_r;
            valid_next_s = 1'b0;
         end
      end
   end

   // State registers; clr_fifo overrides every other input.
   always_ff @(posedge clk) begin
      if (clr_fifo) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         dout_r   <= '0;
         valid_r  <= 1'b0;
         ovf_r    <= 1'b0;
         udf_r    <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         end
         rd_ptr_r <= rd_ptr_next_s;
         count_r  <= count_next_s;
         dout_r   <= dout_next_s;
         valid_r  <= valid_next_s;
         if (wr_fifo && full_s) begin
            ovf_r <= 1'b1;
         end
         if (rd_fifo && empty_s) begin
            udf_r <= 1'b1;
         end
      end
   end

   assign data_out       = dout_r;
   assign data_out_valid = valid_r;
   assign data_counter   = count_r;
   assign empty          = empty_s;
   assign full           = full_s;
   assign almost_full    = (count_r >= AF_LVL_C);
   assign almost_empty   = (count_r <= AE_LVL_C);
   assign overflow       = ovf_r;
   assign underflow      = udf_r;

endmodule
